// File: rtl/iq_mixer_if.sv
// Bus bundle for iq_mixer_pipe.
// master: upstream/bench side (drives LO samples, RF, mode, sat_clr).
// slave : mixer side (drives rf_out, out_valid, I/Q outputs, sat_count).
interface iq_mixer_if #(
  parameter int unsigned LO_WIDTH = 12,
  parameter int unsigned RF_WIDTH = 1
);
  logic                       in_valid;
  logic signed [LO_WIDTH-1:0] sinewave_in;
  logic signed [LO_WIDTH-1:0] cosinewave_in;
  logic [RF_WIDTH-1:0]        rf_in;
  logic [1:0]                 mode;
  logic                       sat_clr;
  logic [RF_WIDTH-1:0]        rf_out;
  logic                       out_valid;
  logic signed [LO_WIDTH-1:0] sinewave_out;
  logic signed [LO_WIDTH-1:0] cosinewave_out;
  logic [15:0]                sat_count;

  modport master (
    output in_valid, sinewave_in, cosinewave_in, rf_in, mode, sat_clr,
    input  rf_out, out_valid, sinewave_out, cosinewave_out, sat_count
  );

  modport slave (
    input  in_valid, sinewave_in, cosinewave_in, rf_in, mode, sat_clr,
    output rf_out, out_valid, sinewave_out, cosinewave_out, sat_count
  );
endinterface

// File: rtl/iq_mixer_pipe.sv
// Pipelined I/Q mixer: RF sample (1-bit comparator or signed multi-bit)
// times NCO sine/cosine, with RF alignment delay, round/saturate, run-time
// mode select and a saturation event counter.
// Ports: clk, rst_n (synchronous, active low), bus (iq_mixer_if.slave):
//   in_valid/sinewave_in/cosinewave_in/rf_in/mode/sat_clr in,
//   rf_out/out_valid/sinewave_out/cosinewave_out/sat_count out.
module iq_mixer_pipe #(
  parameter int unsigned LO_WIDTH = 12,
  parameter int unsigned RF_WIDTH = 1,
  parameter int unsigned RF_DELAY = 2
) (
  input logic        clk,
  input logic        rst_n,
  iq_mixer_if.slave  bus
);

  // Working width: full product plus one bit for the mode-11 negation.
  localparam int unsigned PW  = LO_WIDTH + RF_WIDTH + 1;
  localparam int unsigned DL  = (RF_DELAY > 0) ? RF_DELAY : 1;
  localparam int unsigned RSH = (RF_WIDTH > 1) ? RF_WIDTH - 1 : 1;
  localparam logic signed [PW-1:0] RND   = PW'(2 ** (RSH - 1));
  localparam logic signed [PW-1:0] P_MAX = PW'((2 ** (LO_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] P_MIN = ~P_MAX;
  // Comparator idles high (-1); multi-bit samples idle at zero.
  localparam logic [RF_WIDTH-1:0] RF_IDLE = (RF_WIDTH == 1) ? {RF_WIDTH{1'b1}} : '0;

  // RF delay line; rf_q[k] holds rf_in delayed k+1 clocks.
  logic [RF_WIDTH-1:0] rf_q [DL];
  logic [RF_WIDTH-1:0] rf_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DL); k++) rf_q[k] <= RF_IDLE;
    end else begin
      rf_q[0] <= bus.rf_in;
      for (int k = 1; k < int'(DL); k++) rf_q[k] <= rf_q[k-1];
    end
  end

  generate
    if (RF_DELAY == 0) begin : g_rf_comb
      assign rf_sel = bus.rf_in;
    end else begin : g_rf_dly
      assign rf_sel = rf_q[RF_DELAY-1];
    end
  endgenerate

  // Stage 1: capture operands and mode of each accepted sample.
  logic                       s1_vld_q;
  logic [RF_WIDTH-1:0]        s1_rf_q;
  logic signed [LO_WIDTH-1:0] s1_sin_q;
  logic signed [LO_WIDTH-1:0] s1_cos_q;
  logic [1:0]                 s1_mode_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_rf_q   <= RF_IDLE;
      s1_sin_q  <= '0;
      s1_cos_q  <= '0;
      s1_mode_q <= '0;
    end else begin
      s1_vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_rf_q   <= rf_sel;
        s1_sin_q  <= bus.sinewave_in;
        s1_cos_q  <= bus.cosinewave_in;
        s1_mode_q <= bus.mode;
      end
    end
  end

  // One channel: returns {clipped, saturated result}.
  function automatic logic [LO_WIDTH:0] mix_ch(
    input logic signed [LO_WIDTH-1:0] x,
    input logic [RF_WIDTH-1:0]        r,
    input logic [1:0]                 m
  );
    logic signed [PW-1:0] xw;
    logic signed [PW-1:0] rw;
    logic signed [PW-1:0] p;
    logic                 sat;
    logic [LO_WIDTH-1:0]  y;
    xw = PW'(x);
    rw = PW'($signed(r));
    if (RF_WIDTH == 1) p = r[0] ? -xw : xw;
    else               p = (rw * xw + RND) >>> RSH;
    case (m)
      2'b01:   p = xw;
      2'b10:   p = '0;
      2'b11:   p = -p;
      default: ;
    endcase
    sat = 1'b0;
    y   = LO_WIDTH'(p);
    if (p > P_MAX) begin
      sat = 1'b1;
      y   = LO_WIDTH'(P_MAX);
    end else if (p < P_MIN) begin
      sat = 1'b1;
      y   = LO_WIDTH'(P_MIN);
    end
    return {sat, y};
  endfunction

  // Stage 2: output registers and saturation counter.
  logic [LO_WIDTH:0]          mix_sin;
  logic [LO_WIDTH:0]          mix_cos;
  logic signed [LO_WIDTH-1:0] sin_d, sin_q;
  logic signed [LO_WIDTH-1:0] cos_d, cos_q;
  logic                       vld_d, vld_q;
  logic [15:0]                cnt_d, cnt_q;

  always_comb begin
    mix_sin = mix_ch(s1_sin_q, s1_rf_q, s1_mode_q);
    mix_cos = mix_ch(s1_cos_q, s1_rf_q, s1_mode_q);
    sin_d   = sin_q;
    cos_d   = cos_q;
    vld_d   = s1_vld_q;
    cnt_d   = cnt_q;
    if (s1_vld_q) begin
      sin_d = mix_sin[LO_WIDTH-1:0];
      cos_d = mix_cos[LO_WIDTH-1:0];
      if ((mix_sin[LO_WIDTH] || mix_cos[LO_WIDTH]) && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    // Clear wins over a coincident increment.
    if (bus.sat_clr) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sin_q <= '0;
      cos_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sin_q <= sin_d;
      cos_q <= cos_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.rf_out         = rf_q[0];
  assign bus.out_valid      = vld_q;
  assign bus.sinewave_out   = sin_q;
  assign bus.cosinewave_out = cos_q;
  assign bus.sat_count      = cnt_q;

endmodule

// File: tb/tb_iq_mixer_pipe.sv
// Self-checking bench: a 1-bit comparator mixer (RF_DELAY=2) and a 4-bit
// mixer (RF_DELAY=0) driven side by side.
module tb_iq_mixer_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  iq_mixer_if #(.LO_WIDTH(12), .RF_WIDTH(1)) if1 ();
  iq_mixer_if #(.LO_WIDTH(12), .RF_WIDTH(4)) if4 ();

  iq_mixer_pipe #(.LO_WIDTH(12), .RF_WIDTH(1), .RF_DELAY(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  iq_mixer_pipe #(.LO_WIDTH(12), .RF_WIDTH(4), .RF_DELAY(0)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] rf4;
    int         sin;
    int         cos;
    int         e4s;
    int         e4c;
    bit         s4;
    int         e1s;
    int         e1c;
    bit         s1;
  } vec_t;

  vec_t tv [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int cnt1;
  int cnt4;
  int hs;
  int hc;
  int vpat [7];

  initial begin
    checks   = 0;
    failures = 0;
    // All mode/rf values at table row: u1 rf held at 1 so mix gives -x.
    tv[0] = '{2'b00, 4'h8,  2047,     0, -2047,     0, 1'b0, -2047,     0, 1'b0};
    tv[1] = '{2'b00, 4'h7, -2048,   100, -1792,    88, 1'b0,  2047,  -100, 1'b1};
    tv[2] = '{2'b00, 4'h8, -2048, -2048,  2047,  2047, 1'b1,  2047,  2047, 1'b1};
    tv[3] = '{2'b00, 4'h0,  1234,   -77,     0,     0, 1'b0, -1234,    77, 1'b0};
    tv[4] = '{2'b00, 4'h1,   300,  -300,    38,   -37, 1'b0,  -300,   300, 1'b0};
    tv[5] = '{2'b01, 4'h5,   300, -2048,   300, -2048, 1'b0,   300, -2048, 1'b0};
    tv[6] = '{2'b10, 4'h5,   300,     7,     0,     0, 1'b0,     0,     0, 1'b0};
    tv[7] = '{2'b11, 4'h8,   300, -2048,   300, -2048, 1'b0,   300, -2048, 1'b0};
    tv[8] = '{2'b11, 4'h2,  2047,    -1,  -512,     0, 1'b0,  2047,    -1, 1'b0};
    tv[9] = '{2'b01, 4'h0, -2048,  2047, -2048,  2047, 1'b0, -2048,  2047, 1'b0};
    vpat  = '{1, 0, 0, 1, 1, 0, 0};

    rst_n = 1'b0;
    if1.in_valid = 1'b1; if1.sinewave_in = 12'sd100; if1.cosinewave_in = -12'sd200;
    if1.rf_in = 1'b0; if1.mode = 2'b00; if1.sat_clr = 1'b0;
    if4.in_valid = 1'b1; if4.sinewave_in = 12'sd100; if4.cosinewave_in = -12'sd200;
    if4.rf_in = 4'h3; if4.mode = 2'b00; if4.sat_clr = 1'b0;

    // Reset held 3 clocks with activity on the inputs.
    for (int i = 0; i < 3; i++) begin
      if1.rf_in = ~if1.rf_in;
      tick();
      chk("rst_valid1", int'(if1.out_valid), 0);
      chk("rst_sin1", int'(if1.sinewave_out), 0);
      chk("rst_cos1", int'(if1.cosinewave_out), 0);
      chk("rst_sat1", int'(if1.sat_count), 0);
      chk("rst_rfout1", int'(if1.rf_out), 1);
      chk("rst_valid4", int'(if4.out_valid), 0);
      chk("rst_rfout4", int'(if4.rf_out), 0);
    end

    // Release; first out_valid two clocks later.
    rst_n = 1'b1;
    if1.rf_in = 1'b0;
    if4.in_valid = 1'b0;
    tick();
    chk("rel_valid_e1", int'(if1.out_valid), 0);
    tick();
    chk("rel_valid_e2", int'(if1.out_valid), 1);
    tick(); tick(); tick();
    chk("pre_step_sin", int'(if1.sinewave_out), 100);
    chk("pre_step_cos", int'(if1.cosinewave_out), -200);
    chk("pre_step_rfout", int'(if1.rf_out), 0);

    // RF step reaches the output RF_DELAY+2 clocks later.
    if1.rf_in = 1'b1;
    tick();
    chk("step_rfout", int'(if1.rf_out), 1);
    chk("step_e1_sin", int'(if1.sinewave_out), 100);
    tick();
    chk("step_e2_sin", int'(if1.sinewave_out), 100);
    tick();
    chk("step_e3_sin", int'(if1.sinewave_out), 100);
    chk("step_e3_cos", int'(if1.cosinewave_out), -200);
    tick();
    chk("step_e4_sin", int'(if1.sinewave_out), -100);
    chk("step_e4_cos", int'(if1.cosinewave_out), 200);

    // Back-to-back table with per-sample mode changes.
    cnt1 = 0;
    cnt4 = 0;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        if1.in_valid = 1'b1; if4.in_valid = 1'b1;
        if1.mode = tv[i].mode; if4.mode = tv[i].mode;
        if4.rf_in = tv[i].rf4;
        if1.sinewave_in = 12'(tv[i].sin); if1.cosinewave_in = 12'(tv[i].cos);
        if4.sinewave_in = 12'(tv[i].sin); if4.cosinewave_in = 12'(tv[i].cos);
      end else begin
        if1.in_valid = 1'b0; if4.in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        if (tv[i-1].s4) cnt4++;
        if (tv[i-1].s1) cnt1++;
        chk($sformatf("tv%0d_valid4", i-1), int'(if4.out_valid), 1);
        chk($sformatf("tv%0d_sin4", i-1), int'(if4.sinewave_out), tv[i-1].e4s);
        chk($sformatf("tv%0d_cos4", i-1), int'(if4.cosinewave_out), tv[i-1].e4c);
        chk($sformatf("tv%0d_sat4", i-1), int'(if4.sat_count), cnt4);
        chk($sformatf("tv%0d_valid1", i-1), int'(if1.out_valid), 1);
        chk($sformatf("tv%0d_sin1", i-1), int'(if1.sinewave_out), tv[i-1].e1s);
        chk($sformatf("tv%0d_cos1", i-1), int'(if1.cosinewave_out), tv[i-1].e1c);
        chk($sformatf("tv%0d_sat1", i-1), int'(if1.sat_count), cnt1);
      end
    end

    // Continuous clipping on the sine channel.
    if1.mode = 2'b00;
    if1.in_valid = 1'b1;
    if1.sinewave_in = -12'sd2048;
    if1.cosinewave_in = 12'sd5;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      cnt1++;
      chk("clip_sin", int'(if1.sinewave_out), 2047);
      chk("clip_cos", int'(if1.cosinewave_out), -5);
      chk("clip_cnt", int'(if1.sat_count), cnt1);
    end
    for (int k = 0; k < 65540; k++) tick();
    chk("cnt_ceiling", int'(if1.sat_count), 65535);
    tick();
    chk("cnt_hold", int'(if1.sat_count), 65535);
    if1.sat_clr = 1'b1;
    tick();
    chk("clr_priority", int'(if1.sat_count), 0);
    if1.sat_clr = 1'b0;
    tick();
    chk("clr_then_inc", int'(if1.sat_count), 1);
    if1.in_valid = 1'b0;
    tick();
    chk("drain_inc", int'(if1.sat_count), 2);
    tick();
    chk("drain_idle_cnt", int'(if1.sat_count), 2);
    chk("drain_idle_valid", int'(if1.out_valid), 0);

    // Valid gaps: out_valid follows in_valid, outputs hold in gaps.
    hs = 2047;
    hc = -5;
    for (int i = 0; i < 7; i++) begin
      if1.in_valid = vpat[i][0];
      if1.sinewave_in = 12'(10 * (i + 1));
      if1.cosinewave_in = 12'(i + 1);
      tick();
      if (i >= 1) begin
        if (vpat[i-1] == 1) begin
          hs = -10 * i;
          hc = -i;
        end
        chk($sformatf("gap%0d_valid", i-1), int'(if1.out_valid), vpat[i-1]);
        chk($sformatf("gap%0d_sin", i-1), int'(if1.sinewave_out), hs);
        chk($sformatf("gap%0d_cos", i-1), int'(if1.cosinewave_out), hc);
      end
    end
    chk("gap_cnt", int'(if1.sat_count), 2);

    // One-clock reset mid-burst drops the in-flight sample.
    if1.in_valid = 1'b1;
    if1.sinewave_in = 12'sd500;
    if1.cosinewave_in = -12'sd600;
    tick();
    tick();
    chk("burst_valid", int'(if1.out_valid), 1);
    chk("burst_sin", int'(if1.sinewave_out), -500);
    rst_n = 1'b0;
    if1.sinewave_in = 12'sd700;
    tick();
    chk("mrst_valid0", int'(if1.out_valid), 0);
    chk("mrst_sin0", int'(if1.sinewave_out), 0);
    chk("mrst_cnt0", int'(if1.sat_count), 0);
    rst_n = 1'b1;
    if1.sinewave_in = 12'sd800;
    if1.cosinewave_in = -12'sd900;
    tick();
    chk("mrst_valid1", int'(if1.out_valid), 0);
    chk("mrst_sin1", int'(if1.sinewave_out), 0);
    if1.in_valid = 1'b0;
    tick();
    chk("mrst_valid2", int'(if1.out_valid), 1);
    chk("mrst_sin2", int'(if1.sinewave_out), -800);
    chk("mrst_cos2", int'(if1.cosinewave_out), 900);
    tick();
    chk("mrst_valid3", int'(if1.out_valid), 0);
    chk("mrst_hold3", int'(if1.sinewave_out), -800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
